req_sched: RTL
==============

# req_sched

Request scheduler sitting directly upstream of the factorial stage (`func_t`). It collects one-hot or multi-hot request vectors into a pending bitmap and selects the highest-index pending request using the same priority rule as the 8-to-3 encoder. It then issues that index as the 4-bit operand `n` over a valid/ready handshake and clears the serviced bit. It also keeps a wrapping grant counter and a sticky drop flag for requests that collide with an already-pending bit.

## Interface
- `WIDTH`, 8, number of request lines; legal range 2..16.
- `N_W`, 4, width of issued operand; must satisfy WIDTH <= 2**N_W.
- `CNT_W`, 16, width of grant counter.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  qualifies `req_in` this cycle.
- `req_in`  in  WIDTH  request vector; bit i requests operand i.
- `out_valid`  out  1  `out_n` holds a granted index.
- `out_ready`  in  1  consumer accepts `out_n` this cycle.
- `out_n`  out  N_W  granted index, zero-extended.
- `pending`  out  WIDTH  current pending bitmap (registered).
- `grant_cnt`  out  CNT_W  number of completed out handshakes, wraps.
- `dropped`  out  1  sticky; set on any colliding request.

## Operation
- Reset (synchronous, active-high) forces the following values: `pending`=0, `out_valid`=0, `out_n`=0, `grant_cnt`=0, `dropped`=0.
  - Reset wins over every other event in the same cycle.
  - Reset mid-handshake discards the held grant without counting it.
- Accept: when `req_valid`=1, `pending_next |= req_in`.
- Selection:
  - `sel` is the priority encode of `pending` (registered value, not including this cycle's `req_in`). The highest set bit wins.
  - `sel_any` = |`pending`.
- Output slot load condition: `load` = `sel_any` && (!`out_valid` || `out_ready`).
- On `load`:
  - `out_n` <= {0, `sel`}.
  - `out_valid` <= 1.
  - Bit `sel` is cleared from `pending`.
- If `out_valid` && `out_ready` && !`sel_any`: `out_valid` <= 0; `out_n` holds its last value.
- Simultaneous set and clear on the same bit: the set wins. The bit stays pending, and this is not a drop.
- Drop: `dropped` <= 1 when `req_valid` && (`req_in` & `pending` & ~clear_mask) != 0. No other state changes because of a drop.
- `grant_cnt` increments by 1 on every cycle with `out_valid` && `out_ready`. It wraps from 2**CNT_W-1 to 0.
- Bits of `req_in` at or above WIDTH do not exist. `out_n` upper bits are always 0.

## Timing
- Request to `out_valid` latency is 2 cycles when the slot is free:
  - Edge 1: the request enters `pending`.
  - Edge 2: the output loads.
- Sustained throughput is one grant per cycle while `out_ready`=1 and `pending`≠0.
- `out_n` and `out_valid` are stable while `out_valid`=1 and `out_ready`=0. A higher-priority request arriving meanwhile does not pre-empt the held grant.
- All outputs are registered; there is no combinational path from `out_ready` or `req_in` to any output.

## Structure
- Shared package holds:
  - `WIDTH`, `N_W` and `CNT_W` defaults.
  - A `clog2` constant function.
  - An elaboration check that WIDTH <= 2**N_W.
- One sub-module: `prio_enc_n`.
  - Parameterised WIDTH-to-index priority encoder; highest index wins.
  - Outputs `idx` and `any`.
  - Purely combinational; instantiated once on `pending`.
- The top holds `pending`, the output slot, `grant_cnt` and `dropped`. Expected size is about 150 lines.

## Test plan
- Reset then idle: hold `reset`=1 for 2 cycles, then release with no requests.
  - Required: all outputs 0 for 10 cycles.
- Single request: `req_in`=8'h10 with `req_valid` for 1 cycle, `out_ready`=1.
  - Required: `out_valid`=1 with `out_n`=4 exactly 2 cycles later, for 1 cycle.
  - Required: `grant_cnt`=1 and `pending`=0 afterwards.
- Priority order: `req_in`=8'hA5 for 1 cycle, `out_ready`=1.
  - Required: consecutive `out_n` values 7, 5, 2, 0.
  - Required: `grant_cnt`=4, `dropped`=0.
- Backpressure: `req_in`=8'h03, `out_ready`=0 for 5 cycles, then `req_in`=8'h80, then `out_ready`=1.
  - Required: `out_n`=1 held stable throughout the stall.
  - Required: then 7, then 0.
- Collision and set-wins:
  - Re-request bit 2 while it is pending and not being granted. Required: `dropped` goes to 1 and stays 1.
  - Request bit 6 in the same cycle bit 6 is loaded. Required: bit 6 is granted again later, and `dropped` is unaffected by this event.
- Counter wrap and mid-operation reset:
  - Use CNT_W=4 and make 17 grants. Required: `grant_cnt`=1.
  - Assert `reset` while `out_valid`=1 and `out_ready`=0. Required: all outputs 0 the next cycle.

Source files
------------

// File: rtl/req_sched_pkg.sv
// req_sched shared package: parameter defaults and elaboration-time helpers.
package req_sched_pkg;

   localparam int REQ_WIDTH = 8;
   localparam int REQ_N_W   = 4;
   localparam int REQ_CNT_W = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Legal request width, and every request index must fit the operand.
   function automatic bit fits(input int width, input int n_w);
      return (width >= 2) && (width <= 16) && (n_w < 31)
         && (width <= (1 << n_w));
   endfunction

   localparam bit REQ_CFG_OK = fits(REQ_WIDTH, REQ_N_W);

endpackage

// File: rtl/req_sched_if.sv
// Request side and grant side of the scheduler, plus its status taps.
interface req_sched_if #(
   parameter int WIDTH = 8,
   parameter int N_W   = 4,
   parameter int CNT_W = 16
) ();

   logic             req_valid;
   logic [WIDTH-1:0] req_in;
   logic             out_valid;
   logic             out_ready;
   logic [N_W-1:0]   out_n;
   logic [WIDTH-1:0] pending;
   logic [CNT_W-1:0] grant_cnt;
   logic             dropped;

   modport master (
      output req_valid, req_in, out_ready,
      input  out_valid, out_n, pending, grant_cnt, dropped
   );

   modport slave (
      input  req_valid, req_in, out_ready,
      output out_valid, out_n, pending, grant_cnt, dropped
   );

endinterface

// File: rtl/req_sched_prio_enc_n.sv
// WIDTH-to-index priority encoder; the highest set bit wins.
module prio_enc_n
   import req_sched_pkg::*;
#(
   parameter int WIDTH = REQ_WIDTH,
   parameter int IW    = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] req,
   output logic [IW-1:0]    idx,
   output logic             any
);

   // Ascending scan so the last hit, the highest index, sticks.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (req[i]) begin
            idx = IW'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/req_sched.sv
// Pending-bitmap request scheduler feeding one index per handshake downstream.
module req_sched
   import req_sched_pkg::*;
#(
   parameter int WIDTH = REQ_WIDTH,
   parameter int N_W   = REQ_N_W,
   parameter int CNT_W = REQ_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   req_sched_if.slave bus
);

   localparam int SEL_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

   if (!fits(WIDTH, N_W)) begin : g_cfg_err
      $error("req_sched: need 2 <= WIDTH <= 16 and WIDTH <= 2**N_W");
   end

   logic [WIDTH-1:0] pending_q, pending_d;
   logic             out_valid_q, out_valid_d;
   logic [N_W-1:0]   out_n_q, out_n_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dropped_q, dropped_d;

   logic [SEL_W-1:0] sel;
   logic             sel_any;
   logic             load;
   logic             fire;
   logic [WIDTH-1:0] clr_mask;
   logic [WIDTH-1:0] req_m;

   prio_enc_n #(
      .WIDTH (WIDTH),
      .IW    (SEL_W)
   ) u_enc (
      .req (pending_q),
      .idx (sel),
      .any (sel_any)
   );

   assign fire  = out_valid_q & bus.out_ready;
   assign load  = sel_any & (~out_valid_q | bus.out_ready);
   assign req_m = bus.req_valid ? bus.req_in : '0;

   always_comb begin
      clr_mask = '0;
      if (load) clr_mask[sel] = 1'b1;
   end

   // Sets are OR'd in after the clear, so a same-cycle set wins.
   always_comb begin
      pending_d   = (pending_q & ~clr_mask) | req_m;
      dropped_d   = dropped_q | (|(req_m & pending_q & ~clr_mask));
      cnt_d       = cnt_q + CNT_W'(fire);
      out_valid_d = out_valid_q;
      out_n_d     = out_n_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_n_d     = N_W'(sel);
      end else if (fire) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q   <= '0;
         out_valid_q <= 1'b0;
         out_n_q     <= '0;
         cnt_q       <= '0;
         dropped_q   <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_n_q     <= out_n_d;
         cnt_q       <= cnt_d;
         dropped_q   <= dropped_d;
      end
   end

   assign bus.pending   = pending_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_n     = out_n_q;
   assign bus.grant_cnt = cnt_q;
   assign bus.dropped   = dropped_q;

endmodule
